// File: rtl/cpu_pkg.sv
// Shared constants, opcode map, FSM state encoding and decode helpers for the
// 16-bit stack-machine core.
package cpu_pkg;

  localparam int unsigned OPCODE_W  = 5;
  localparam int unsigned OPERAND_W = 11;
  localparam int unsigned PC_W      = 11;

  localparam logic [OPCODE_W-1:0] OP_NOP    = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_PUSH_I = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_PUSH   = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_POP    = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD    = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_MUL    = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_AND    = 5'd7;
  localparam logic [OPCODE_W-1:0] OP_OR     = 5'd8;
  localparam logic [OPCODE_W-1:0] OP_XOR    = 5'd9;
  localparam logic [OPCODE_W-1:0] OP_NOT    = 5'd10;
  localparam logic [OPCODE_W-1:0] OP_JMP    = 5'd16;
  localparam logic [OPCODE_W-1:0] OP_JZ     = 5'd17;
  localparam logic [OPCODE_W-1:0] OP_CALL   = 5'd20;
  localparam logic [OPCODE_W-1:0] OP_RET    = 5'd21;

  localparam int unsigned LAT_NO_POP  = 4;
  localparam int unsigned LAT_ONE_POP = 6;
  localparam int unsigned LAT_TWO_POP = 8;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_POP1,
    S_POP1_RD,
    S_POP2,
    S_POP2_RD,
    S_EXEC,
    S_WRITE
  } state_e;

  // Operands consumed; RET pops the return stack, all others the data stack.
  function automatic logic [1:0] pop_count(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: pop_count = 2'd2;
      OP_POP, OP_NOT, OP_JZ, OP_RET:                 pop_count = 2'd1;
      default:                                       pop_count = 2'd0;
    endcase
  endfunction

  function automatic logic pushes_data(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_PUSH_I, OP_PUSH, OP_ADD, OP_SUB, OP_MUL,
      OP_AND, OP_OR, OP_XOR, OP_NOT: pushes_data = 1'b1;
      default:                       pushes_data = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_stack_ram.sv
// Single-port RAM with registered (one-cycle) read; read returns old data on
// a same-address write.
module cpu_stack_ram #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu.sv
// Multi-cycle 16-bit stack-machine core: data stack, return stack and data
// memory, one instruction per FETCH..WRITE pass.
module cpu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 16,
  parameter int unsigned AWIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH_DATA-1:0] instruction,
  output logic [WIDTH_DATA-1:0] tos,
  output logic [AWIDTH:0]       sp,
  output logic [PC_W-1:0]       pc,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  typedef logic [AWIDTH:0] depth_t;

  state_e                state_q, state_d;
  logic [WIDTH_DATA-1:0] instr_q, instr_d;
  logic [WIDTH_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH_DATA-1:0] tos_q, tos_d;
  depth_t                sp_q, sp_d, rsp_q, rsp_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  err_q, err_d, done_q, done_d;

  logic [AWIDTH-1:0]     ds_addr, rs_addr;
  logic                  ds_we, rs_we, dm_we;
  logic [WIDTH_DATA-1:0] ds_rdata, dm_rdata, result;
  logic [PC_W-1:0]       rs_rdata, pc_inc;

  logic [OPCODE_W-1:0]   op;
  logic [OPERAND_W-1:0]  operand;
  logic [1:0]            npop, dpop;
  logic                  is_ret, push_ok, d_uflow, d_oflow, r_uflow, r_oflow;
  depth_t                sp_pop;

  assign op      = instr_q[WIDTH_DATA-1 -: OPCODE_W];
  assign operand = instr_q[OPERAND_W-1:0];
  assign npop    = pop_count(op);
  assign is_ret  = (op == OP_RET);
  assign dpop    = is_ret ? 2'd0 : npop;
  assign pc_inc  = pc_q + PC_W'(1);

  // Data stack depth after this instruction's pops, clamped at empty.
  assign sp_pop  = (sp_q >= depth_t'(dpop)) ? sp_q - depth_t'(dpop) : '0;
  assign d_uflow = (sp_q < depth_t'(dpop));
  assign d_oflow = pushes_data(op) && (sp_pop == depth_t'(DEPTH));
  assign push_ok = pushes_data(op) && !d_oflow;
  assign r_uflow = is_ret && (rsp_q == '0);
  assign r_oflow = (op == OP_CALL) && (rsp_q == depth_t'(DEPTH));

  always_comb begin
    result = '0;
    case (op)
      OP_PUSH_I: result = WIDTH_DATA'(operand);
      OP_PUSH:   result = dm_rdata;
      OP_ADD:    result = a_q + b_q;
      OP_SUB:    result = a_q - b_q;
      OP_MUL:    result = a_q * b_q;
      OP_AND:    result = a_q & b_q;
      OP_OR:     result = a_q | b_q;
      OP_XOR:    result = a_q ^ b_q;
      OP_NOT:    result = ~b_q;
      default:   result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    tos_d   = tos_q;
    sp_d    = sp_q;
    rsp_d   = rsp_q;
    pc_d    = pc_q;
    err_d   = err_q;
    ds_addr = AWIDTH'(sp_q - depth_t'(1));
    rs_addr = AWIDTH'(rsp_q - depth_t'(1));
    ds_we   = 1'b0;
    rs_we   = 1'b0;
    dm_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_d = instruction;
        state_d = S_DECODE;
      end
      S_DECODE:  state_d = (npop != 2'd0) ? S_POP1 : S_EXEC;
      S_POP1:    state_d = S_POP1_RD;
      S_POP1_RD: begin
        if (is_ret) b_d = (rsp_q != '0) ? WIDTH_DATA'(rs_rdata) : '0;
        else        b_d = (sp_q != '0) ? ds_rdata : '0;
        state_d = (npop == 2'd2) ? S_POP2 : S_EXEC;
      end
      S_POP2: begin
        ds_addr = AWIDTH'(sp_q - depth_t'(2));
        state_d = S_POP2_RD;
      end
      S_POP2_RD: begin
        a_d     = (sp_q >= depth_t'(2)) ? ds_rdata : '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Prefetch the post-pop top entry so tos is right when nothing is pushed.
        ds_addr = AWIDTH'(sp_pop - depth_t'(1));
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ds_addr = AWIDTH'(sp_pop);
        ds_we   = push_ok;
        rs_addr = AWIDTH'(rsp_q);
        rs_we   = (op == OP_CALL) && !r_oflow;
        dm_we   = (op == OP_POP);
        sp_d    = sp_pop + depth_t'(push_ok);
        tos_d   = push_ok ? result : ((sp_pop == '0) ? '0 : ds_rdata);
        err_d   = err_q | d_uflow | d_oflow | r_uflow | r_oflow;
        case (op)
          OP_JMP:  pc_d = operand;
          OP_JZ:   pc_d = (b_q == '0) ? operand : pc_inc;
          OP_CALL: pc_d = operand;
          OP_RET:  pc_d = b_q[PC_W-1:0];
          default: pc_d = pc_inc;
        endcase
        if (op == OP_CALL && !r_oflow) rsp_d = rsp_q + depth_t'(1);
        if (is_ret && !r_uflow)        rsp_d = rsp_q - depth_t'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    done_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tos_q   <= '0;
      sp_q    <= '0;
      rsp_q   <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tos_q   <= tos_d;
      sp_q    <= sp_d;
      rsp_q   <= rsp_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  cpu_stack_ram #(.WIDTH(WIDTH_DATA), .AWIDTH(AWIDTH)) u_data_stack (
    .clk(clk), .we(ds_we), .addr(ds_addr), .wdata(result), .rdata(ds_rdata)
  );

  cpu_stack_ram #(.WIDTH(PC_W), .AWIDTH(AWIDTH)) u_return_stack (
    .clk(clk), .we(rs_we), .addr(rs_addr), .wdata(pc_inc), .rdata(rs_rdata)
  );

  cpu_stack_ram #(.WIDTH(WIDTH_DATA), .AWIDTH(AWIDTH)) u_data_mem (
    .clk(clk), .we(dm_we), .addr(operand[AWIDTH-1:0]), .wdata(b_q), .rdata(dm_rdata)
  );

  assign tos  = tos_q;
  assign sp   = sp_q;
  assign pc   = pc_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_cpu.sv
// Bench for the stack-machine core: directed program plus random instruction
// stream, checked against a queue-based instruction-level model.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] tos;
  logic [5:0]  sp;
  logic [10:0] pc;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_ds[$];
  logic [10:0] m_rs[$];
  logic [15:0] m_mem[32];
  bit          m_written[32];
  logic [10:0] m_pc;
  bit          m_err;

  always #5 clk = ~clk;

  cpu #(.WIDTH_DATA(16), .AWIDTH(5)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .tos(tos), .sp(sp), .pc(pc), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int latency(input int op);
    if (op >= 4 && op <= 9) return 8;
    if (op == 3 || op == 10 || op == 17 || op == 21) return 6;
    return 4;
  endfunction

  task automatic m_push(input logic [15:0] v);
    if (m_ds.size() == 32) m_err = 1;
    else m_ds.push_back(v);
  endtask

  task automatic m_pop(output logic [15:0] v);
    if (m_ds.size() == 0) begin m_err = 1; v = 16'd0; end
    else v = m_ds.pop_back();
  endtask

  task automatic model_exec(input int op, input int opd);
    logic [15:0] a, b;
    logic [10:0] next_pc;
    longint prod;
    next_pc = m_pc + 11'd1;
    case (op)
      1: m_push(16'(opd));
      2: m_push(m_mem[opd % 32]);
      3: begin m_pop(b); m_mem[opd % 32] = b; m_written[opd % 32] = 1; end
      4, 5, 6, 7, 8, 9: begin
        m_pop(b);
        m_pop(a);
        case (op)
          4: m_push(16'((int'(a) + int'(b)) % 65536));
          5: m_push(16'((int'(a) - int'(b) + 65536) % 65536));
          6: begin prod = longint'(a) * longint'(b); m_push(16'(prod % 65536)); end
          7: m_push(a & b);
          8: m_push(a | b);
          default: m_push(a ^ b);
        endcase
      end
      10: begin m_pop(b); m_push(~b); end
      16: next_pc = 11'(opd);
      17: begin m_pop(b); if (b == 0) next_pc = 11'(opd); end
      20: begin
        if (m_rs.size() == 32) m_err = 1;
        else m_rs.push_back(m_pc + 11'd1);
        next_pc = 11'(opd);
      end
      21: begin
        if (m_rs.size() == 0) begin m_err = 1; next_pc = 11'd0; end
        else next_pc = m_rs.pop_back();
      end
      default: ;
    endcase
    m_pc = next_pc;
  endtask

  // Drive one instruction for its full latency, then compare visible state.
  task automatic run(input int op, input int opd);
    int lat;
    logic [7:0] mask;
    instruction = {5'(op), 11'(opd)};
    model_exec(op, opd);
    lat = latency(op);
    mask = '0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (done) mask[k-1] = 1'b1;
    end
    check($sformatf("done_op%0d", op), 32'(mask), 32'(1) << (lat - 2));
    check($sformatf("tos_op%0d", op), 32'(tos), 32'((m_ds.size() == 0) ? 16'd0 : m_ds[$]));
    check($sformatf("sp_op%0d", op), 32'(sp), 32'(m_ds.size()));
    check($sformatf("pc_op%0d", op), 32'(pc), 32'(m_pc));
    check($sformatf("err_op%0d", op), 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_tos", 32'(tos), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    m_ds.delete();
    m_rs.delete();
    m_pc = '0;
    m_err = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int ops[18] = '{0, 1, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 16, 17, 20, 21, 13};
    int op, opd;
    reset = 1'b1;
    instruction = '0;
    m_pc = '0;
    m_err = 0;
    @(posedge clk);
    #1;
    do_reset();

    run(1, 5);
    run(1, 2);
    check("tp_tos_2", 32'(tos), 32'd2);
    check("tp_sp_2", 32'(sp), 32'd2);
    run(4, 0);
    check("tp_add", 32'(tos), 32'd7);
    check("tp_add_pc", 32'(pc), 32'd3);
    run(20, 5);
    check("tp_call", 32'(pc), 32'd5);
    run(21, 0);
    check("tp_ret", 32'(pc), 32'd4);
    run(1, 3);
    run(5, 0);
    check("tp_sub", 32'(tos), 32'd4);
    run(1, 2047);
    run(1, 2047);
    run(6, 0);
    check("tp_mul", 32'(tos), 32'hF001);
    check("tp_mul_sp", 32'(sp), 32'd2);

    do_reset();
    run(3, 0);
    check("tp_pop_empty_err", 32'(err), 32'd1);
    check("tp_pop_empty_sp", 32'(sp), 32'd0);

    do_reset();
    repeat (32) run(1, 1);
    check("tp_full_no_err", 32'(err), 32'd0);
    run(1, 1);
    check("tp_overflow_sp", 32'(sp), 32'd32);
    check("tp_overflow_err", 32'(err), 32'd1);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      op  = ops[$urandom_range(0, 17)];
      opd = int'($urandom_range(0, 2047));
      if (op == 2 && !m_written[opd % 32]) op = 1;
      run(op, opd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
